// File: rtl/prbs_test_ctrl.sv
// prbs_test_ctrl: sequences one PRBS_15 test run.
//   IDLE : generator held in reset (gen_rst=0); waits for start.
//   LOAD : releases generator reset, feeds NUM_BYTES seed bytes, LSB byte first.
//   RUN  : runs run_len cycles, counting det_found pulses (saturating).
//   DONE : one-cycle done pulse; pass = (found_cnt == exp_found).
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-low reset
//   start, abort    run request (IDLE only) / cancel an active LOAD or RUN
//   pattern         seed bytes, [7:0] sent first
//   rep_n           repeat count forwarded to the generator n input
//   run_len         RUN-phase length in cycles
//   exp_found       expected detector hit count
//   det_found       detector hit pulse
//   gen_rst         generator reset (active-low)
//   gen_data        generator data_in
//   gen_n           generator n
//   busy            high in LOAD and RUN
//   done            one-cycle pulse at the end of a completed run
//   pass            found_cnt == exp_found, valid from done
//   found_cnt       hits counted in the current/last run
module prbs_test_ctrl #(
  parameter int unsigned NUM_BYTES = 4,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [8*NUM_BYTES-1:0] pattern,
  input  logic [1:0]             rep_n,
  input  logic [CNT_W-1:0]       run_len,
  input  logic [CNT_W-1:0]       exp_found,
  input  logic                   det_found,
  output logic                   gen_rst,
  output logic [7:0]             gen_data,
  output logic [1:0]             gen_n,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [CNT_W-1:0]       found_cnt
);

  localparam int unsigned PAT_W = 8 * NUM_BYTES;
  localparam int unsigned IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d, idx_nxt;
  logic [CNT_W-1:0]   run_cnt_q, run_cnt_d;
  logic [PAT_W-1:0]   pattern_q, pattern_d;
  logic [CNT_W-1:0]   run_len_q, run_len_d;
  logic [CNT_W-1:0]   exp_q, exp_d;

  logic               gen_rst_d;
  logic [7:0]         gen_data_d;
  logic [1:0]         gen_n_d;
  logic               busy_d;
  logic               done_d;
  logic               pass_d;
  logic [CNT_W-1:0]   found_d;
  logic [CNT_W-1:0]   found_sat;
  logic [CNT_W-1:0]   found_nxt;

  // Saturating increment of the hit counter
  assign found_sat = (found_cnt == {CNT_W{1'b1}}) ? found_cnt : CNT_W'(found_cnt + 1'b1);

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    idx_nxt    = IDX_W'(idx_q + 1'b1);
    run_cnt_d  = run_cnt_q;
    pattern_d  = pattern_q;
    run_len_d  = run_len_q;
    exp_d      = exp_q;
    gen_rst_d  = gen_rst;
    gen_data_d = gen_data;
    gen_n_d    = gen_n;
    busy_d     = busy;
    done_d     = 1'b0;
    pass_d     = pass;
    found_d    = found_cnt;
    found_nxt  = det_found ? found_sat : found_cnt;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          pattern_d  = pattern;
          run_len_d  = run_len;
          exp_d      = exp_found;
          found_d    = '0;
          pass_d     = 1'b0;
          idx_d      = '0;
          state_d    = S_LOAD;
          gen_rst_d  = 1'b1;
          gen_data_d = pattern[7:0];
          gen_n_d    = rep_n;
          busy_d     = 1'b1;
        end
      end

      S_LOAD: begin
        if (abort) begin
          state_d    = S_IDLE;
          gen_rst_d  = 1'b0;
          gen_data_d = '0;
          gen_n_d    = '0;
          busy_d     = 1'b0;
          pass_d     = 1'b0;
        end else if (idx_q == IDX_W'(NUM_BYTES - 1)) begin
          // Last seed byte has been presented; gen_data keeps it from here on
          run_cnt_d = '0;
          if (run_len_q != '0) begin
            state_d = S_RUN;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            pass_d  = (found_cnt == exp_q);
          end
        end else begin
          idx_d      = idx_nxt;
          gen_data_d = 8'(pattern_q >> {idx_nxt, 3'b000});
        end
      end

      S_RUN: begin
        if (abort) begin
          // Partial hit count is kept for inspection
          state_d    = S_IDLE;
          gen_rst_d  = 1'b0;
          gen_data_d = '0;
          gen_n_d    = '0;
          busy_d     = 1'b0;
          pass_d     = 1'b0;
        end else begin
          found_d   = found_nxt;
          run_cnt_d = CNT_W'(run_cnt_q + 1'b1);
          if (run_cnt_q == CNT_W'(run_len_q - 1'b1)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            pass_d  = (found_nxt == exp_q);
          end
        end
      end

      S_DONE: begin
        // abort and start are both ignored here
        state_d    = S_IDLE;
        gen_rst_d  = 1'b0;
        gen_data_d = '0;
        gen_n_d    = '0;
        busy_d     = 1'b0;
      end

      default: begin
        state_d    = S_IDLE;
        gen_rst_d  = 1'b0;
        gen_data_d = '0;
        gen_n_d    = '0;
        busy_d     = 1'b0;
      end
    endcase
  end

  // State, context and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      run_cnt_q <= '0;
      pattern_q <= '0;
      run_len_q <= '0;
      exp_q     <= '0;
      gen_rst   <= 1'b0;
      gen_data  <= '0;
      gen_n     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      found_cnt <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      run_cnt_q <= run_cnt_d;
      pattern_q <= pattern_d;
      run_len_q <= run_len_d;
      exp_q     <= exp_d;
      gen_rst   <= gen_rst_d;
      gen_data  <= gen_data_d;
      gen_n     <= gen_n_d;
      busy      <= busy_d;
      done      <= done_d;
      pass      <= pass_d;
      found_cnt <= found_d;
    end
  end

endmodule

// File: tb/tb_prbs_test_ctrl.sv
// Testbench for prbs_test_ctrl: table of directed runs plus hand-written
// reset / abort sequences. Inputs are driven and outputs sampled on negedge.
module tb_prbs_test_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [31:0] pattern;
  logic [1:0]  rep_n;
  logic [7:0]  run_len;
  logic [7:0]  exp_found;
  logic        det_found;
  logic        gen_rst;
  logic [7:0]  gen_data;
  logic [1:0]  gen_n;
  logic        busy;
  logic        done;
  logic        pass;
  logic [7:0]  found_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  prbs_test_ctrl #(.NUM_BYTES(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .pattern   (pattern),
    .rep_n     (rep_n),
    .run_len   (run_len),
    .exp_found (exp_found),
    .det_found (det_found),
    .gen_rst   (gen_rst),
    .gen_data  (gen_data),
    .gen_n     (gen_n),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .found_cnt (found_cnt)
  );

  // hits bit k drives det_found into edge E(4+k): bit 0 lands on the last
  // LOAD edge (must be ignored), bits 1..run_len on the RUN edges.
  // abort_t / restart_t: t (cycles after start edge) at which abort / start is
  // driven for the following edge; -1 = never.
  typedef struct {
    logic [31:0] pattern;
    logic [1:0]  rep_n;
    logic [7:0]  run_len;
    logic [7:0]  exp_found;
    logic [63:0] hits;
    bit          det_hold;
    int          abort_t;
    int          restart_t;
    bit          exp_done;
    int          exp_lat;
    bit          exp_pass;
    logic [7:0]  exp_cnt;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int t;
    bit done_seen;
    int pulses;
    // Entered just after a negedge
    pattern   = v.pattern;
    rep_n     = v.rep_n;
    run_len   = v.run_len;
    exp_found = v.exp_found;
    start     = 1'b1;
    abort     = 1'b0;
    det_found = 1'b0;
    @(negedge clk);
    // Scramble inputs: the captured run must not be affected
    start     = 1'b0;
    pattern   = ~v.pattern;
    rep_n     = ~v.rep_n;
    run_len   = v.run_len ^ 8'h5A;
    exp_found = ~v.exp_found;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      chk($sformatf("v%0d gen_data[%0d]", id, k), 32'(gen_data), 32'((v.pattern >> (8 * k)) & 32'hFF));
      chk($sformatf("v%0d gen_rst load%0d", id, k), 32'(gen_rst), 32'd1);
      if (k == 0) begin
        chk($sformatf("v%0d gen_n", id), 32'(gen_n), 32'(v.rep_n));
        chk($sformatf("v%0d busy", id), 32'(busy), 32'd1);
        chk($sformatf("v%0d found_cnt cleared", id), 32'(found_cnt), 32'd0);
      end
    end
    t = 3;
    done_seen = 1'b0;
    forever begin
      det_found = v.det_hold ? 1'b1 : (((t - 3) < 64) ? v.hits[t - 3] : 1'b0);
      abort     = (t == v.abort_t);
      start     = (t == v.restart_t);
      @(negedge clk);
      t++;
      abort     = 1'b0;
      start     = 1'b0;
      det_found = 1'b0;
      if (done) begin
        done_seen = 1'b1;
        break;
      end
      if (v.abort_t >= 0 && t == v.abort_t + 1) break;
      if (t > 400) break;
    end
    chk($sformatf("v%0d done seen", id), 32'(done_seen), 32'(v.exp_done));
    if (v.exp_done) begin
      chk($sformatf("v%0d done latency", id), 32'(t), 32'(v.exp_lat));
      chk($sformatf("v%0d busy at done", id), 32'(busy), 32'd0);
      chk($sformatf("v%0d gen_rst at done", id), 32'(gen_rst), 32'd1);
      chk($sformatf("v%0d pass", id), 32'(pass), 32'(v.exp_pass));
      chk($sformatf("v%0d found_cnt", id), 32'(found_cnt), 32'(v.exp_cnt));
      abort = (t == v.abort_t);
      @(negedge clk);
      abort = 1'b0;
      chk($sformatf("v%0d done width", id), 32'(done), 32'd0);
      chk($sformatf("v%0d gen_rst idle", id), 32'(gen_rst), 32'd0);
      chk($sformatf("v%0d pass hold", id), 32'(pass), 32'(v.exp_pass));
      chk($sformatf("v%0d found_cnt hold", id), 32'(found_cnt), 32'(v.exp_cnt));
    end else begin
      chk($sformatf("v%0d busy after abort", id), 32'(busy), 32'd0);
      chk($sformatf("v%0d gen_rst after abort", id), 32'(gen_rst), 32'd0);
      chk($sformatf("v%0d pass after abort", id), 32'(pass), 32'd0);
      chk($sformatf("v%0d found_cnt after abort", id), 32'(found_cnt), 32'(v.exp_cnt));
    end
    pulses = 0;
    repeat (5) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    chk($sformatf("v%0d stays idle", id), 32'(pulses), 32'd0);
  endtask

  initial begin
    //          pattern       rep   len    exp    hits     hold  abrt rst  done lat pass cnt
    vecs[0] = '{32'hFFEEDDCC, 2'd2, 8'd8,  8'd3,  64'h113, 1'b0, -1,  -1,  1'b1, 12, 1'b1, 8'd3};
    vecs[1] = '{32'hFFEEDDCC, 2'd2, 8'd8,  8'd2,  64'h113, 1'b0, -1,  -1,  1'b1, 12, 1'b0, 8'd3};
    vecs[2] = '{32'h12345678, 2'd1, 8'd0,  8'd0,  64'h1,   1'b0, -1,  -1,  1'b1, 4,  1'b1, 8'd0};
    vecs[3] = '{32'hA5A55A5A, 2'd3, 8'd10, 8'd1,  64'h2,   1'b0, 6,   5,   1'b0, 0,  1'b0, 8'd1};
    vecs[4] = '{32'h01020304, 2'd0, 8'd5,  8'd2,  64'h24,  1'b0, -1,  6,   1'b1, 9,  1'b1, 8'd2};
    vecs[5] = '{32'hCAFEBABE, 2'd2, 8'd3,  8'd0,  64'h1,   1'b0, 3,   -1,  1'b0, 0,  1'b0, 8'd0};
    vecs[6] = '{32'h0BADF00D, 2'd1, 8'd2,  8'd0,  64'h0,   1'b0, 6,   -1,  1'b1, 6,  1'b1, 8'd0};
    vecs[7] = '{32'h00FF00FF, 2'd3, 8'd255, 8'd255, 64'h0, 1'b1, -1,  -1,  1'b1, 259, 1'b1, 8'd255};

    rst       = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    pattern   = '0;
    rep_n     = '0;
    run_len   = '0;
    exp_found = '0;
    det_found = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset gen_rst", 32'(gen_rst), 32'd0);
    chk("reset gen_data", 32'(gen_data), 32'd0);
    chk("reset gen_n", 32'(gen_n), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset pass", 32'(pass), 32'd0);
    chk("reset found_cnt", 32'(found_cnt), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // abort beats start in IDLE
    start = 1'b1;
    abort = 1'b1;
    pattern = 32'h11223344;
    run_len = 8'd3;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("idle abort+start busy", 32'(busy), 32'd0);
    chk("idle abort+start gen_rst", 32'(gen_rst), 32'd0);

    for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

    // Async reset in the middle of RUN
    pattern   = 32'h55AA33CC;
    rep_n     = 2'd1;
    run_len   = 8'd20;
    exp_found = 8'd0;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    det_found = 1'b1;
    repeat (8) @(negedge clk);
    chk("midrun found_cnt", 32'(found_cnt), 32'd4);
    chk("midrun busy", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("async rst gen_rst", 32'(gen_rst), 32'd0);
    chk("async rst busy", 32'(busy), 32'd0);
    chk("async rst found_cnt", 32'(found_cnt), 32'd0);
    chk("async rst gen_data", 32'(gen_data), 32'd0);
    start = 1'b1;
    @(negedge clk);
    chk("start during rst busy", 32'(busy), 32'd0);
    chk("start during rst gen_rst", 32'(gen_rst), 32'd0);
    start     = 1'b0;
    det_found = 1'b0;
    rst       = 1'b1;
    repeat (2) @(negedge clk);
    chk("after rst release busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
